// File: rtl/exe_div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one op in flight.
// Latency: XLEN/BITS_PER_CYCLE + 2 cycles from accept to div_valid (2 on the fast path).
// Backpressure: ix_div_ready only in IDLE; div_valid is a one-cycle strobe, never stalled.
//
// Ports:
//   clk, rst (async active-low)    clock / reset
//   wb_do_branch                   flush: blocks accept, kills CALC/FIXUP work
//   ix_div_valid/ready/op/rs1/rs2/rd   issue handshake and operands from IX
//   div_valid/div_rd/div_result    result strobe to WB (rd/result hold until next FIXUP)
// Optional build macro: DIV_FAST_PATH_EN (zero divisor or |rs1| < |rs2| skips CALC).
module exe_div_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int RD_W           = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_do_branch,
    input  logic            ix_div_valid,
    output logic            ix_div_ready,
    input  logic [1:0]      ix_div_op,
    input  logic [XLEN-1:0] ix_div_rs1,
    input  logic [XLEN-1:0] ix_div_rs2,
    input  logic [RD_W-1:0] ix_div_rd,
    output logic            div_valid,
    output logic [RD_W-1:0] div_rd,
    output logic [XLEN-1:0] div_result
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d;       // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]   rem_q, rem_d;       // restored remainder, always < divisor
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              rem_sel_q, rem_sel_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic              div_valid_q, div_valid_d;
    logic [RD_W-1:0]   div_rd_q, div_rd_d;
    logic [XLEN-1:0]   div_result_q, div_result_d;

    logic              op_signed;
    logic              accept;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // Working partial remainder is XLEN+1 bits (shifted remainder plus next dividend bit).
    logic [XLEN:0]     step_sh;
    logic [XLEN-1:0]   step_diff;
    logic [XLEN-1:0]   step_rem;
    logic [XLEN-1:0]   step_quo;

    assign op_signed    = ~ix_div_op[0];
    assign accept       = (state_q == S_IDLE) && ix_div_valid && !wb_do_branch;
    assign rs1_mag      = (op_signed && ix_div_rs1[XLEN-1]) ? -ix_div_rs1 : ix_div_rs1;
    assign rs2_mag      = (op_signed && ix_div_rs2[XLEN-1]) ? -ix_div_rs2 : ix_div_rs2;
    assign quo_fix      = neg_q_q ? -quo_q : quo_q;
    assign rem_fix      = neg_r_q ? -rem_q : rem_q;
    assign ix_div_ready = (state_q == S_IDLE);
    assign div_valid    = div_valid_q;
    assign div_rd       = div_rd_q;
    assign div_result   = div_result_q;

    // Restoring division steps. When the subtraction succeeds the true difference is
    // below the divisor, so the low XLEN bits of the modular difference are exact.
    // A zero divisor always "succeeds": quotient all ones, remainder = dividend.
    always_comb begin
        step_rem  = rem_q;
        step_quo  = quo_q;
        step_sh   = '0;
        step_diff = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_sh   = {step_rem, step_quo[XLEN-1]};
            step_quo  = {step_quo[XLEN-2:0], 1'b0};
            step_diff = step_sh[XLEN-1:0] - dvs_q;
            if (step_sh >= {1'b0, dvs_q}) begin
                step_rem    = step_diff;
                step_quo[0] = 1'b1;
            end else begin
                step_rem = step_sh[XLEN-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        rem_sel_d    = rem_sel_q;
        rd_d         = rd_q;
        neg_q_d      = neg_q_q;
        neg_r_d      = neg_r_q;
        div_valid_d  = 1'b0;
        div_rd_d     = div_rd_q;
        div_result_d = div_result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    quo_d     = rs1_mag;
                    rem_d     = '0;
                    dvs_d     = rs2_mag;
                    rem_sel_d = ix_div_op[1];
                    rd_d      = ix_div_rd;
                    // Divide by zero keeps the all-ones quotient unsigned.
                    neg_q_d   = op_signed && (ix_div_rs1[XLEN-1] ^ ix_div_rs2[XLEN-1])
                                && (ix_div_rs2 != '0);
                    neg_r_d   = op_signed && ix_div_rs1[XLEN-1];
                    cnt_d     = CNT_W'(STEPS);
                    state_d   = S_CALC;
`ifdef DIV_FAST_PATH_EN
                    if ((rs2_mag == '0) || (rs1_mag < rs2_mag)) begin
                        quo_d   = (rs2_mag == '0) ? '1 : '0;
                        rem_d   = rs1_mag;
                        cnt_d   = '0;
                        state_d = S_FIXUP;
                    end
`endif
                end
            end
            S_CALC: begin
                if (wb_do_branch) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIXUP;
                    end
                end
            end
            S_FIXUP: begin
                if (wb_do_branch) begin
                    state_d = S_IDLE;
                end else begin
                    div_valid_d  = 1'b1;
                    div_rd_d     = rd_q;
                    div_result_d = rem_sel_q ? rem_fix : quo_fix;
                    state_d      = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            rem_sel_q    <= 1'b0;
            rd_q         <= '0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            div_valid_q  <= 1'b0;
            div_rd_q     <= '0;
            div_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            rem_sel_q    <= rem_sel_d;
            rd_q         <= rd_d;
            neg_q_q      <= neg_q_d;
            neg_r_q      <= neg_r_d;
            div_valid_q  <= div_valid_d;
            div_rd_q     <= div_rd_d;
            div_result_q <= div_result_d;
        end
    end

endmodule

// File: tb/tb_exe_div_iter.sv
// Bench for exe_div_iter: a default 32-bit instance and a 16-bit, 2-bits-per-cycle instance.
// Stimulus pushes expected results; a forked monitor pops and compares on div_valid.
module tb_exe_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 32-bit instance
    logic        rst32, br32, v32, rdy32, dv32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, res32;
    logic [4:0]  rd32, drd32;
    // 16-bit instance
    logic        rst16, br16, v16, rdy16, dv16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, res16;
    logic [4:0]  rd16, drd16;

    exe_div_iter u_d32 (
        .clk(clk), .rst(rst32), .wb_do_branch(br32),
        .ix_div_valid(v32), .ix_div_ready(rdy32), .ix_div_op(op32),
        .ix_div_rs1(a32), .ix_div_rs2(b32), .ix_div_rd(rd32),
        .div_valid(dv32), .div_rd(drd32), .div_result(res32)
    );

    exe_div_iter #(.XLEN(16), .BITS_PER_CYCLE(2), .RD_W(5)) u_d16 (
        .clk(clk), .rst(rst16), .wb_do_branch(br16),
        .ix_div_valid(v16), .ix_div_ready(rdy16), .ix_div_op(op16),
        .ix_div_rs1(a16), .ix_div_rs2(b16), .ix_div_rd(rd16),
        .div_valid(dv16), .div_rd(drd16), .div_result(res16)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
    } vec_t;

    exp_t q32[$];
    exp_t q16[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_dv32 = 0;
    int   n_dv16 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Independent reference: RISC-V semantics on w-bit operands via 64-bit arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        longint mask, full, ua, ub, sa, sb, q, r;
        logic [63:0] t;
        full = longint'(1) << w;
        mask = full - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        if (op[0]) begin
            if (ub == 0) begin q = mask; r = ua; end
            else begin q = ua / ub; r = ua % ub; end
        end else begin
            sa = (ua >= full / 2) ? ua - full : ua;
            sb = (ub >= full / 2) ? ub - full : ub;
            if (sb == 0) begin q = -1; r = sa; end
            else if (sa == -(full / 2) && sb == -1) begin q = sa; r = 0; end
            else begin q = sa / sb; r = sa % sb; end
        end
        t = 64'(op[1] ? r : q) & 64'(mask);
        return t[31:0];
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int w);
        int steps;
        longint full, ma, mb;
        steps = (w == 16) ? 8 : 32;
        full = longint'(1) << w;
        ma = longint'(a) & (full - 1);
        mb = longint'(b) & (full - 1);
        if (!op[0] && ma >= full / 2) ma = full - ma;
        if (!op[0] && mb >= full / 2) mb = full - mb;
`ifdef DIV_FAST_PATH_EN
        if (mb == 0 || ma < mb) return 2;
`endif
        return steps + 2;
    endfunction

    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] res);
        int t = 0;
        exp_t e;
        @(negedge clk);
        v32 = 1'b1; op32 = op; a32 = a; b32 = b; rd32 = rd;
        while (!rdy32 && t < 100) begin @(negedge clk); t++; end
        chk("accept32_ready", rdy32, 1'b1);
        e.res = res; e.rd = rd; e.lat = exp_lat(op, a, b, 32); e.acc = cyc;
        q32.push_back(e);
        @(negedge clk);
        v32 = 1'b0;
        t = 0;
        while (q32.size() != 0 && t < 100) begin @(negedge clk); t++; end
        if (q32.size() != 0) begin
            chk("drain32", q32.size(), 0);
            q32.delete();
        end
    endtask

    task automatic issue16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] rd, input logic [15:0] res);
        int t = 0;
        exp_t e;
        @(negedge clk);
        v16 = 1'b1; op16 = op; a16 = a; b16 = b; rd16 = rd;
        while (!rdy16 && t < 100) begin @(negedge clk); t++; end
        chk("accept16_ready", rdy16, 1'b1);
        e.res = {16'h0, res}; e.rd = rd; e.lat = exp_lat(op, {16'h0, a}, {16'h0, b}, 16);
        e.acc = cyc;
        q16.push_back(e);
        @(negedge clk);
        v16 = 1'b0;
        t = 0;
        while (q16.size() != 0 && t < 100) begin @(negedge clk); t++; end
        if (q16.size() != 0) begin
            chk("drain16", q16.size(), 0);
            q16.delete();
        end
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{2'b01, 32'd100,       32'd7,         5'd3,  32'd14};
        vecs[1]  = '{2'b11, 32'd100,       32'd7,         5'd3,  32'd2};
        vecs[2]  = '{2'b00, 32'hFFFFFF9C,  32'd7,         5'd4,  32'hFFFFFFF2};
        vecs[3]  = '{2'b10, 32'hFFFFFF9C,  32'd7,         5'd5,  32'hFFFFFFFE};
        vecs[4]  = '{2'b10, 32'd100,       32'hFFFFFFF9,  5'd6,  32'd2};
        vecs[5]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF,  5'd7,  32'h80000000};
        vecs[6]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  5'd8,  32'h0};
        vecs[7]  = '{2'b00, 32'd5,         32'd0,         5'd9,  32'hFFFFFFFF};
        vecs[8]  = '{2'b10, 32'hFFFFFFFB,  32'd0,         5'd10, 32'hFFFFFFFB};
        vecs[9]  = '{2'b11, 32'd7,         32'd100,       5'd11, 32'd7};
        vecs[10] = '{2'b01, 32'hFFFFFFFF,  32'd1,         5'd31, 32'hFFFFFFFF};
        vecs[11] = '{2'b00, 32'hFFFFFFF9,  32'd2,         5'd12, 32'hFFFFFFFD};

        rst32 = 1'b0; br32 = 1'b0; v32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; rd32 = '0;
        rst16 = 1'b0; br16 = 1'b0; v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; rd16 = '0;

        // Monitor: compare every div_valid against the head of the scoreboard.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst32 && dv32) begin
                    n_dv32++;
                    if (q32.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_valid32: got div_valid=1 result=0x%0h, required no strobe", res32);
                    end else begin
                        e = q32.pop_front();
                        chk("result32", res32, e.res);
                        chk("rd32", drd32, e.rd);
                        chk("latency32", cyc - e.acc, e.lat);
                    end
                end
                if (rst16 && dv16) begin
                    n_dv16++;
                    if (q16.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_valid16: got div_valid=1 result=0x%0h, required no strobe", res16);
                    end else begin
                        e = q16.pop_front();
                        chk("result16", res16, e.res[15:0]);
                        chk("rd16", drd16, e.rd);
                        chk("latency16", cyc - e.acc, e.lat);
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", dv32, 1'b0);
        chk("rst_result", res32, 32'h0);
        chk("rst_rd", drd32, 5'h0);
        rst32 = 1'b1; rst16 = 1'b1;
        @(negedge clk);
        chk("rst_ready32", rdy32, 1'b1);
        chk("rst_ready16", rdy16, 1'b1);

        // Directed 32-bit vectors
        for (int i = 0; i < 12; i++)
            issue32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res);
        repeat (3) @(negedge clk);
        chk("hold_result32", res32, 32'hFFFFFFFD);
        chk("hold_rd32", drd32, 5'd12);

        // Flush in CALC: DIVU 1000/3, branch in cycle 10 after accept.
        begin
            int t = 0;
            int dv_before;
            dv_before = n_dv32;
            @(negedge clk);
            v32 = 1'b1; op32 = 2'b01; a32 = 32'd1000; b32 = 32'd3; rd32 = 5'd13;
            while (!rdy32 && t < 100) begin @(negedge clk); t++; end
            @(negedge clk);
            v32 = 1'b0;
            repeat (4) @(negedge clk);
            chk("busy_ready32", rdy32, 1'b0);
            repeat (5) @(negedge clk);
            br32 = 1'b1;
            @(negedge clk);
            br32 = 1'b0;
            chk("flush_ready32", rdy32, 1'b1);
            // Valid with branch in the same cycle must not be accepted.
            v32 = 1'b1; br32 = 1'b1; op32 = 2'b01; a32 = 32'd1000; b32 = 32'd3;
            @(negedge clk);
            chk("branch_block_ready32", rdy32, 1'b1);
            v32 = 1'b0; br32 = 1'b0;
            repeat (45) @(negedge clk);
            chk("flush_no_result32", n_dv32, dv_before);
        end

        // 16-bit, 2 bits per cycle
        issue16(2'b01, 16'hFFFF, 16'h0010, 5'd1, 16'h0FFF);
        for (int i = 0; i < 30; i++) begin
            logic [15:0] a, b;
            logic [1:0]  op;
            logic [31:0] r;
            op = 2'(i % 4);
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            case (i % 6)
                0: b = 16'h0;
                1: begin a = 16'h8000; b = 16'hFFFF; end
                2: b = 16'($urandom_range(1, 15));
                default: ;
            endcase
            r = ref_div(op, {16'h0, a}, {16'h0, b}, 16);
            issue16(op, a, b, 5'(i), r[15:0]);
        end

        // Reset dropped mid-CALC
        issue16(2'b01, 16'h00FF, 16'h0001, 5'd7, 16'h00FF);
        begin
            int t = 0;
            int dv_before;
            dv_before = n_dv16;
            @(negedge clk);
            v16 = 1'b1; op16 = 2'b01; a16 = 16'h1234; b16 = 16'h0003; rd16 = 5'd9;
            while (!rdy16 && t < 100) begin @(negedge clk); t++; end
            @(negedge clk);
            v16 = 1'b0;
            repeat (3) @(negedge clk);
            rst16 = 1'b0;
            #1;
            chk("midrst_valid16", dv16, 1'b0);
            chk("midrst_result16", res16, 16'h0);
            chk("midrst_rd16", drd16, 5'h0);
            @(negedge clk);
            rst16 = 1'b1;
            @(negedge clk);
            chk("postrst_ready16", rdy16, 1'b1);
            repeat (15) @(negedge clk);
            chk("midrst_no_result16", n_dv16, dv_before);
        end
        issue16(2'b01, 16'h0064, 16'h0007, 5'd2, 16'h000E);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exe_div_iter.md
Name: exe_div_iter

Overview:
- Parametrised iterative divider execution unit for the RV integer pipeline: DIV/DIVU/REM/REMU, issued from IX, result written back to WB.
- Generalises the fixed-width, fixed-latency pipelined divider:
  - configurable XLEN and quotient bits retired per cycle;
  - explicit ready back-pressure to IX;
  - flush of in-flight work on a WB branch;
  - correct RISC-V divide-by-zero and overflow results without vendor IP.
- Holds one operation at a time.

Parameters:
- XLEN, 32: operand/result width; must be even and ≥ 8.
- BITS_PER_CYCLE, 1: quotient bits resolved per CALC cycle; 1 or 2; XLEN must be divisible by it.
- RD_W, 5: destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_do_branch  in  1  WB flush; squashes accept and in-flight work.
- ix_div_valid  in  1  IX presents an op.
- ix_div_ready  out  1  unit can accept; high only in IDLE.
- ix_div_op  in  2  bit0 = unsigned, bit1 = remainder: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- ix_div_rs1  in  XLEN  dividend.
- ix_div_rs2  in  XLEN  divisor.
- ix_div_rd  in  RD_W  destination register.
- div_valid  out  1  one-cycle result strobe to WB.
- div_rd  out  RD_W  destination of the result.
- div_result  out  XLEN  quotient or remainder.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; counter = 0;
  - div_valid = 0, div_rd = 0, div_result = 0;
  - ix_div_ready = 1 once rst deasserts.
- Accept:
  - Accept fires when state == IDLE, ix_div_valid = 1 and wb_do_branch = 0.
  - If wb_do_branch = 1 in that cycle, nothing is accepted.
- On accept, latch:
  - magnitude of each operand (negate it if op is signed and MSB is set);
  - op; rd;
  - neg_q = signed & (rs1[MSB] ^ rs2[MSB]) & (rs2 != 0);
  - neg_r = signed & rs1[MSB].
  - Then: counter = XLEN/BITS_PER_CYCLE; go to CALC.
- CALC: restoring division, BITS_PER_CYCLE quotient bits per cycle.
  - Partial remainder is XLEN+1 bits wide.
  - Counter decrements each cycle; at counter == 1 go to FIXUP.
- FIXUP:
  - Select quotient (bit1 = 0) or remainder (bit1 = 1).
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Register into div_result/div_rd; set div_valid = 1; go to DONE.
- DONE:
  - div_valid is high for exactly this one cycle; then clear div_valid and go to IDLE.
  - div_result and div_rd hold their values until the next FIXUP.
- Latency: accept edge to div_valid high = XLEN/BITS_PER_CYCLE + 2 cycles (34 for default parameters).
- Throughput: one op per XLEN/BITS_PER_CYCLE + 3 cycles. The next accept can occur in the cycle after DONE.
- Flush:
  - wb_do_branch = 1 while in CALC or FIXUP → next state IDLE; no div_valid is produced.
  - wb_do_branch during DONE does not retract div_valid; WB owns that filtering.
- Divide by zero falls out of the algorithm:
  - quotient = all ones;
  - remainder = rs1 (neg_r restores the sign; neg_q is suppressed).
- Signed overflow (DIV/REM with rs1 = most-negative, rs2 = −1):
  - quotient = most-negative;
  - remainder = 0.
- No stall from WB: div_valid is never held waiting for an acknowledge.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined:
  - On accept, detect rs2 == 0, or |rs1| < |rs2| (unsigned magnitudes).
  - Either case jumps directly IDLE → FIXUP, loading quotient = all ones (zero divisor) or 0 (small dividend) and remainder = |rs1|.
  - Latency for these cases = 2 cycles; all other cases unchanged.
- Undefined: every op takes the full CALC sequence. Results are bit-identical in both builds.

Test Plan:
- DIVU 100 / 7, rd = 3 (default params): div_valid at cycle 34 after accept, div_result = 14, div_rd = 3. Repeat as REMU: div_result = 2.
- DIV −100 / 7: result = −14 (0xFFFFFFF2). REM −100 / 7: result = −2 (0xFFFFFFFE). REM 100 / −7: result = 2.
- DIV 0x80000000 / 0xFFFFFFFF: result = 0x80000000. REM with the same operands: result = 0.
- DIV 5 / 0: result = 0xFFFFFFFF. REM −5 / 0: result = 0xFFFFFFFB. With DIV_FAST_PATH_EN: div_valid 2 cycles after accept.
- Accept DIVU 1000 / 3; assert wb_do_branch at cycle 10 → no div_valid, ix_div_ready = 1 next cycle. Then ix_div_valid with wb_do_branch = 1 in the same cycle → not accepted.
- XLEN = 16, BITS_PER_CYCLE = 2: DIVU 0xFFFF / 0x0010 → result 0x0FFF, latency 10. Random signed/unsigned sweep against a reference model, including rst dropped mid-CALC (outputs zero immediately, ready after release).
